// File: rtl/fml_ddr3_ctl_if.sv
// FML slave to DDR3 MIG user-interface bridge: one 4-beat FML burst maps to one 256-bit UI command.
// Read and write beats are staged in four-entry buffers so the UI only ever sees whole bursts.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for fml_stb while calibration is complete
// S_RD_CMD  | read command on the UI, held until app_rdy
// S_RD_WAIT | waiting for the single 256-bit read word
// S_RD_OUT  | ack cycle, then four read beats on fml_do
// S_WR_IN   | ack cycle, then four write beats captured from fml_di/fml_sel
// S_WR_CMD  | write command and write data offered until both are accepted
module fml_ddr3_ctl_if #(
    parameter int adr_width  = 30,
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 64
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [adr_width-1:0]        fml_adr,
    input  logic                        fml_stb,
    input  logic                        fml_we,
    output logic                        fml_ack,
    input  logic [DATA_WIDTH/8-1:0]     fml_sel,
    input  logic [DATA_WIDTH-1:0]       fml_di,
    output logic [DATA_WIDTH-1:0]       fml_do,
    input  logic                        app_rdy,
    input  logic [4*DATA_WIDTH-1:0]     app_rd_data,
    input  logic                        app_rd_data_end,
    input  logic                        app_rd_data_valid,
    input  logic                        app_wdf_rdy,
    input  logic                        phy_init_done,
    output logic [ADDR_WIDTH-1:0]       app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    output logic                        app_hi_pri,
    output logic                        app_sz,
    output logic [4*DATA_WIDTH-1:0]     app_wdf_data,
    output logic                        app_wdf_end,
    output logic [4*DATA_WIDTH/8-1:0]   app_wdf_mask,
    output logic                        app_wdf_wren
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_WAIT,
        S_RD_OUT,
        S_WR_IN,
        S_WR_CMD
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2:0]              r_cmd;
    logic                    r_en;
    logic                    r_wren;
    logic                    r_ack;
    logic [DATA_WIDTH-1:0]   r_do;
    logic [2:0]              r_cnt;
    logic [DATA_WIDTH-1:0]   r_rd_buf [4];
    logic [DATA_WIDTH-1:0]   r_wr_buf [4];
    logic [SEL_W-1:0]        r_mask   [4];

    logic [1:0]              w_idx;
    logic                    w_en_nxt;
    logic                    w_wren_nxt;
    logic                    w_unused;

    // Beat index counts up while the burst counter runs down from 4.
    assign w_idx      = 2'(3'd4 - r_cnt);
    assign w_en_nxt   = r_en & ~app_rdy;
    assign w_wren_nxt = r_wren & ~app_wdf_rdy;
    assign w_unused   = ^fml_adr[4:0];

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cmd   <= '0;
            r_en    <= 1'b0;
            r_wren  <= 1'b0;
            r_ack   <= 1'b0;
            r_do    <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_rd_buf[i] <= '0;
                r_wr_buf[i] <= '0;
                r_mask[i]   <= '0;
            end
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fml_stb && phy_init_done) begin
                        r_addr <= {fml_adr[adr_width-1:5], 2'b00};
                        r_cnt  <= 3'd4;
                        if (fml_we) begin
                            r_cmd   <= CMD_WR;
                            r_ack   <= 1'b1;
                            r_state <= S_WR_IN;
                        end else begin
                            r_cmd   <= CMD_RD;
                            r_en    <= 1'b1;
                            r_state <= S_RD_CMD;
                        end
                    end
                end
                S_RD_CMD: begin
                    if (app_rdy) begin
                        r_en    <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (app_rd_data_valid && app_rd_data_end) begin
                        for (int i = 0; i < 4; i++)
                            r_rd_buf[i] <= app_rd_data[4*DATA_WIDTH-1-DATA_WIDTH*i -: DATA_WIDTH];
                        r_ack   <= 1'b1;
                        r_state <= S_RD_OUT;
                    end
                end
                S_RD_OUT: begin
                    if (r_cnt != 3'd0) begin
                        r_do  <= r_rd_buf[w_idx];
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_do    <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_WR_IN: begin
                    // The ack cycle carries no data; beats follow on the next four cycles.
                    if (!r_ack) begin
                        r_wr_buf[w_idx] <= fml_di;
                        r_mask[w_idx]   <= ~fml_sel;
                        r_cnt           <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) begin
                            r_en    <= 1'b1;
                            r_wren  <= 1'b1;
                            r_state <= S_WR_CMD;
                        end
                    end
                end
                S_WR_CMD: begin
                    r_en   <= w_en_nxt;
                    r_wren <= w_wren_nxt;
                    if (!w_en_nxt && !w_wren_nxt)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fml_ack      = r_ack;
    assign fml_do       = r_do;
    assign app_addr     = r_addr;
    assign app_cmd      = r_cmd;
    assign app_en       = r_en;
    assign app_hi_pri   = 1'b0;
    assign app_sz       = 1'b1;
    assign app_wdf_data = {r_wr_buf[0], r_wr_buf[1], r_wr_buf[2], r_wr_buf[3]};
    assign app_wdf_mask = {r_mask[0], r_mask[1], r_mask[2], r_mask[3]};
    assign app_wdf_wren = r_wren;
    assign app_wdf_end  = r_wren;

endmodule

// File: tb/tb_fml_ddr3_ctl_if.sv
// Directed bench for fml_ddr3_ctl_if: reads, writes, masks, calibration stall,
// UI back-pressure and asynchronous reset during a write burst.
module tb_fml_ddr3_ctl_if;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [29:0]   fml_adr;
    logic          fml_stb;
    logic          fml_we;
    logic          fml_ack;
    logic [7:0]    fml_sel;
    logic [63:0]   fml_di;
    logic [63:0]   fml_do;
    logic          app_rdy;
    logic [255:0]  app_rd_data;
    logic          app_rd_data_end;
    logic          app_rd_data_valid;
    logic          app_wdf_rdy;
    logic          phy_init_done;
    logic [26:0]   app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_hi_pri;
    logic          app_sz;
    logic [255:0]  app_wdf_data;
    logic          app_wdf_end;
    logic [31:0]   app_wdf_mask;
    logic          app_wdf_wren;

    int n_checks = 0;
    int n_errors = 0;

    fml_ddr3_ctl_if dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .fml_adr           (fml_adr),
        .fml_stb           (fml_stb),
        .fml_we            (fml_we),
        .fml_ack           (fml_ack),
        .fml_sel           (fml_sel),
        .fml_di            (fml_di),
        .fml_do            (fml_do),
        .app_rdy           (app_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_end   (app_rd_data_end),
        .app_rd_data_valid (app_rd_data_valid),
        .app_wdf_rdy       (app_wdf_rdy),
        .phy_init_done     (phy_init_done),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_hi_pri        (app_hi_pri),
        .app_sz            (app_sz),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_mask      (app_wdf_mask),
        .app_wdf_wren      (app_wdf_wren)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, input int max, output int lat);
        lat = 0;
        while (!fml_ack && lat < max) begin
            tick();
            lat++;
        end
        chk({tag, "_ack_seen"}, fml_ack, 1'b1);
    endtask

    // Call in the ack cycle T: checks beats on T+1..T+4 and fml_do back to 0 after.
    task automatic rd_beats(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] e2, input logic [63:0] e3);
        logic [63:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_beat%0d", tag, i), fml_do, exp[i]);
            chk($sformatf("%s_noack%0d", tag, i), fml_ack, 1'b0);
        end
        tick();
        chk({tag, "_do_idle"}, fml_do, 64'h0);
    endtask

    // Issues a write and feeds the four beats; returns at the first WR_CMD cycle.
    task automatic wr_burst(input string tag, input logic [29:0] adr,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
        logic [63:0] d [4];
        logic [7:0]  s [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        fml_adr = adr; fml_we = 1'b1; fml_stb = 1'b1;
        fml_di = 64'hdead_beef_dead_beef; fml_sel = 8'h00;
        tick();
        chk({tag, "_ack"}, fml_ack, 1'b1);
        fml_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) chk({tag, "_ack_1cyc"}, fml_ack, 1'b0);
            fml_di = d[i]; fml_sel = s[i];
        end
        tick();
        fml_di = 64'h0; fml_sel = 8'h00;
    endtask

    int lat;

    initial begin
        sys_rst = 1'b0;
        fml_adr = '0; fml_stb = 1'b0; fml_we = 1'b0; fml_sel = '0; fml_di = '0;
        app_rdy = 1'b1; app_rd_data_end = 1'b1; app_rd_data_valid = 1'b1; app_wdf_rdy = 1'b1;
        phy_init_done = 1'b1;
        app_rd_data = {64'haaaa_aaaa_aaaa_aaaa, 64'hbbbb_bbbb_bbbb_bbbb,
                       64'hcccc_cccc_cccc_cccc, 64'hdddd_dddd_dddd_dddd};
        tick(); tick();
        chk("rst_ack", fml_ack, 1'b0);
        chk("rst_en", app_en, 1'b0);
        chk("rst_wren", app_wdf_wren, 1'b0);
        chk("rst_outs", {fml_do, app_addr, app_cmd, app_wdf_end, app_wdf_mask}, '0);
        chk("rst_wdata", app_wdf_data, '0);
        chk("const_pri_sz", {app_hi_pri, app_sz}, 2'b01);
        sys_rst = 1'b1;
        tick();

        // Read with every UI input tied high
        fml_adr = 30'h0000_1240; fml_we = 1'b0; fml_stb = 1'b1;
        tick();
        fml_stb = 1'b0;
        chk("rd_en", app_en, 1'b1);
        chk("rd_cmd", app_cmd, 3'b001);
        chk("rd_addr", app_addr, 27'h248);
        wait_ack("rd", 20, lat);
        chk("rd_ack_latency", lat, 2);
        rd_beats("rd", 64'haaaa_aaaa_aaaa_aaaa, 64'hbbbb_bbbb_bbbb_bbbb,
                 64'hcccc_cccc_cccc_cccc, 64'hdddd_dddd_dddd_dddd);

        // Full-mask write
        wr_burst("wr", 30'h0000_0100,
                 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
                 8'hff, 8'hff, 8'hff, 8'hff);
        chk("wr_en", app_en, 1'b1);
        chk("wr_wren_end", {app_wdf_wren, app_wdf_end}, 2'b11);
        chk("wr_cmd", app_cmd, 3'b000);
        chk("wr_addr", app_addr, 27'h0000020);
        chk("wr_data", app_wdf_data, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                                      64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444});
        chk("wr_mask", app_wdf_mask, 32'h0);
        tick();
        chk("wr_done", {app_en, app_wdf_wren, app_wdf_end}, 3'b000);

        // Partial mask on beat 1; command and data accepted on different cycles
        app_rdy = 1'b0;
        wr_burst("wrm", 30'h0000_0fe0,
                 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888,
                 8'hff, 8'h0f, 8'hff, 8'hff);
        chk("wrm_mask", app_wdf_mask, 32'h00f0_0000);
        chk("wrm_addr", app_addr, 27'h00001fc);
        chk("wrm_both", {app_en, app_wdf_wren}, 2'b11);
        tick();
        chk("wrm_split", {app_en, app_wdf_wren, app_wdf_end}, 3'b100);
        tick();
        chk("wrm_en_held", app_en, 1'b1);
        app_rdy = 1'b1;
        tick();
        chk("wrm_en_drop", app_en, 1'b0);

        // Calibration not done: request stalls
        phy_init_done = 1'b0;
        app_rd_data = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                       64'h0f0f_0f0f_0f0f_0f0f, 64'hf0f0_f0f0_f0f0_f0f0};
        fml_adr = 30'h0000_0040; fml_we = 1'b0; fml_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("phy_stall", {fml_ack, app_en}, 2'b00);
        end
        phy_init_done = 1'b1;
        tick();
        fml_stb = 1'b0;
        chk("phy_go_en", app_en, 1'b1);
        chk("phy_go_addr", app_addr, 27'h0000008);
        wait_ack("phy", 20, lat);
        rd_beats("phy", 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                 64'h0f0f_0f0f_0f0f_0f0f, 64'hf0f0_f0f0_f0f0_f0f0);

        // app_rdy low for five cycles in RD_CMD, read data arrives later
        app_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        fml_adr = 30'h0000_0080; fml_we = 1'b0; fml_stb = 1'b1;
        tick();
        fml_stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_en_held", {app_en, app_cmd, fml_ack}, {1'b1, 3'b001, 1'b0});
            tick();
        end
        app_rdy = 1'b1;
        tick();
        chk("bp_en_drop", app_en, 1'b0);
        tick(); tick();
        chk("bp_no_early_ack", fml_ack, 1'b0);
        app_rd_data = {64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
                       64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004};
        app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        wait_ack("bp", 20, lat);
        chk("bp_ack_latency", lat, 1);
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        rd_beats("bp", 64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
                 64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004);

        // Reset asserted in the middle of WR_IN
        fml_adr = 30'h0000_0200; fml_we = 1'b1; fml_stb = 1'b1;
        tick();
        chk("rstw_ack", fml_ack, 1'b1);
        fml_stb = 1'b0;
        tick(); fml_di = 64'h9999_9999_9999_9999; fml_sel = 8'h3c;
        tick(); fml_di = 64'haaaa_5555_aaaa_5555;
        tick();
        #2 sys_rst = 1'b0;
        #1;
        chk("rstw_ctl", {fml_ack, app_en, app_wdf_wren, app_wdf_end}, 4'h0);
        chk("rstw_bufs", app_wdf_data, '0);
        chk("rstw_misc", {fml_do, app_addr, app_cmd, app_wdf_mask}, '0);
        tick();
        sys_rst = 1'b1;
        fml_di = '0; fml_sel = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rstw_quiet", {app_wdf_wren, app_en, fml_ack}, 3'b000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
